// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: bundle between the ID/EX boundary and the ALU control sequencer.
//   master : upstream side (ID/EX register, hazard unit) drives the instruction
//            fields and flush, and observes the control outputs.
//   slave  : alu_ctrl_seq side.
// Signals: id_valid/id_ready handshake, alu_op[1:0], funct7[1:0] ({30,25}),
//          funct3[2:0], flush, alu_ctrl[CTRL_W-1:0], ctrl_valid, busy, done,
//          illegal.
interface alu_ctrl_if #(
    parameter int CTRL_W = 4
);
    logic              id_valid;
    logic              id_ready;
    logic [1:0]        alu_op;
    logic [1:0]        funct7;
    logic [2:0]        funct3;
    logic              flush;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              ctrl_valid;
    logic              busy;
    logic              done;
    logic              illegal;

    modport master (
        output id_valid, alu_op, funct7, funct3, flush,
        input  id_ready, alu_ctrl, ctrl_valid, busy, done, illegal
    );

    modport slave (
        input  id_valid, alu_op, funct7, funct3, flush,
        output id_ready, alu_ctrl, ctrl_valid, busy, done, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode for the EX stage, with sequencing
// of multi-cycle ops (mult = code 1, MUL_LAT cycles; matr = code 8, MATR_LAT
// cycles). While a multi-cycle op runs the code is held and busy stalls ID/EX.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_ctrl_if.slave (instruction fields in, control/status out)
// Optional feature: define ALU_CTRL_ILLEGAL_EN to flag unsupported encodings
// with a one-cycle illegal pulse; otherwise illegal is tied to 0 and such
// encodings decode silently to code 0 as a single-cycle op.
module alu_ctrl_seq #(
    parameter int CTRL_W   = 4,
    parameter int MUL_LAT  = 4,
    parameter int MATR_LAT = 8,
    parameter int CNT_W    = $clog2(((MUL_LAT > MATR_LAT) ? MUL_LAT : MATR_LAT) + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_ctrl_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MC   = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CTRL_W-1:0] CODE_MUL  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] CODE_MATR = CTRL_W'(8);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CTRL_W-1:0] ctrl_q;
    logic              valid_q;
    logic              done_q;

    logic [CTRL_W-1:0] dec_code;
    logic              dec_legal;
    logic              accept;
    logic              is_mc;

    // Decode; unsupported encodings leave code 0 with dec_legal low.
    always_comb begin
        dec_code  = '0;
        dec_legal = 1'b0;
        case (bus.alu_op)
            2'b00: begin dec_code = CTRL_W'(2); dec_legal = 1'b1; end
            2'b01: begin
                case (bus.funct3)
                    3'd0:    begin dec_code = CTRL_W'(5); dec_legal = 1'b1; end
                    3'd5:    begin dec_code = CTRL_W'(7); dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            2'b10: begin
                case ({bus.funct7, bus.funct3})
                    5'b00000: begin dec_code = CTRL_W'(2); dec_legal = 1'b1; end
                    5'b00100: begin dec_code = CTRL_W'(4); dec_legal = 1'b1; end
                    5'b10000: begin dec_code = CTRL_W'(6); dec_legal = 1'b1; end
                    5'b01000: begin dec_code = CODE_MUL;   dec_legal = 1'b1; end
                    5'b00001: begin dec_code = CODE_MATR;  dec_legal = 1'b1; end
                    default:  ;
                endcase
            end
            default: begin
                case (bus.funct3)
                    3'd0:    begin dec_code = CTRL_W'(2); dec_legal = 1'b1; end
                    3'd1:    begin dec_code = CTRL_W'(3); dec_legal = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

    // id_ready depends on the state register only, so input never reaches output.
    assign accept = bus.id_valid && (state != MC);
    assign is_mc  = dec_legal && ((dec_code == CODE_MUL) || (dec_code == CODE_MATR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            cnt     <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (state == MC) begin
            // Code and ctrl_valid are held; counter reaching 1 marks the last busy cycle.
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                state  <= DONE;
                done_q <= 1'b1;
            end
        end else if (accept) begin
            ctrl_q  <= dec_code;
            valid_q <= 1'b1;
            if (is_mc) begin
                state  <= MC;
                done_q <= 1'b0;
                cnt    <= (dec_code == CODE_MUL) ? CNT_W'(MUL_LAT - 1) : CNT_W'(MATR_LAT - 1);
            end else begin
                state  <= DONE;
                done_q <= 1'b1;
            end
        end else begin
            state   <= IDLE;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    logic illegal_q;

    // Pulses only for the single cycle an unsupported encoding occupies EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (bus.flush || state == MC)
            illegal_q <= 1'b0;
        else
            illegal_q <= accept && !dec_legal;
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.busy       = (state == MC);
    assign bus.id_ready   = (state != MC);
    assign bus.alu_ctrl   = ctrl_q;
    assign bus.ctrl_valid = valid_q;
    assign bus.done       = done_q;
endmodule
